// File: rtl/fetch_seq_ctrl_pkg.sv
// Fetch sequencer shared definitions.
// State encodings, datapath widths and the IF/ID control bundle.
package fetch_seq_ctrl_pkg;

    localparam int PC_W   = 32;
    localparam int LEN_W  = 3;
    localparam int CNT_W  = 16;
    localparam int FCNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Longest legal instruction in bytes; longer lengths still advance
    // the PC but raise the sticky length error.
    localparam logic [LEN_W-1:0] MAX_LEN = 3'd5;

    typedef struct packed {
        logic req;
        logic stall;
        logic flush;
    } ifid_ctrl_t;

    function automatic logic len_illegal(input logic [LEN_W-1:0] len);
        return len > MAX_LEN;
    endfunction

endpackage

// File: rtl/fetch_pc_adder.sv
// Fetch PC incrementer.
// Adds the delivered instruction length; carry-out is dropped so the PC wraps.
module fetch_pc_adder
    import fetch_seq_ctrl_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [LEN_W-1:0] len,
    output logic [PC_W-1:0]  sum
);

    assign sum = pc + {{(PC_W-LEN_W){1'b0}}, len};

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencing FSM.
// Drives fetch enable, the fetch PC and IF/ID stall/flush controls.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ack,
    input  logic [LEN_W-1:0]  fetch_len,
    input  logic              dec_stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              fetch_req,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic [1:0]        state_out,
    output logic              len_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD =
        FCNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_sum;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;
    logic              len_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              advance;
    ifid_ctrl_t        ctrl;

    fetch_pc_adder u_adder (
        .pc  (pc_q),
        .len (fetch_len),
        .sum (pc_sum)
    );

    // Next-state, next-PC and IF/ID control decode by state and priority.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fcnt_d     = fcnt_q;
        advance    = 1'b0;
        ctrl.req   = 1'b0;
        ctrl.stall = 1'b0;
        ctrl.flush = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                ctrl.req = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (dec_stall) begin
                    ctrl.stall = 1'b1;
                    ctrl.flush = 1'b0;
                end else if (fetch_ack) begin
                    ctrl.flush = 1'b0;
                    pc_d       = pc_sum;
                    advance    = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and flush counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Sticky flag for an accepted over-long instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err_q <= 1'b0;
        end else if (advance && len_illegal(fetch_len)) begin
            len_err_q <= 1'b1;
        end
    end

    // Saturating count of IF/ID stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (ctrl.stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign fetch_req  = ctrl.req;
    assign ifid_stall = ctrl.stall;
    assign ifid_flush = ctrl.flush;
    assign fetch_pc   = pc_q;
    assign state_out  = state_q;
    assign len_err    = len_err_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for the fetch sequencer.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_ack;
    logic [2:0]  fetch_len;
    logic        dec_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        ifid_stall;
    logic        ifid_flush;
    logic [1:0]  state_out;
    logic        len_err;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    fetch_seq_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ack      (fetch_ack),
        .fetch_len      (fetch_len),
        .dec_stall      (dec_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .state_out      (state_out),
        .len_err        (len_err),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control outputs: state, fetch_req, stall, flush.
    task automatic chk_ctl(input string tag, input logic [1:0] st,
                           input logic req, input logic stl,
                           input logic fl);
        chk({tag, ".state"}, 32'(state_out), 32'(st));
        chk({tag, ".req"}, 32'(fetch_req), 32'(req));
        chk({tag, ".stall"}, 32'(ifid_stall), 32'(stl));
        chk({tag, ".flush"}, 32'(ifid_flush), 32'(fl));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        fetch_ack      = 1'b0;
        fetch_len      = 3'd0;
        dec_stall      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;

        #1;
        chk_ctl("rst", 2'd0, 1'b0, 1'b0, 1'b1);
        chk("rst.pc", fetch_pc, 32'h0);
        chk("rst.len_err", 32'(len_err), 32'h0);
        chk("rst.stall_cnt", 32'(stall_cnt), 32'h0);

        // Release reset; sequential fetch of 3-byte instructions.
        @(negedge clk);
        rst = 1'b0; fetch_ack = 1'b1; fetch_len = 3'd3;
        #1;
        chk_ctl("idle", 2'd0, 1'b0, 1'b0, 1'b1);
        chk("idle.pc", fetch_pc, 32'h0);
        @(negedge clk); #1;
        chk_ctl("run0", 2'd1, 1'b1, 1'b0, 1'b0);
        chk("run0.pc", fetch_pc, 32'h0);
        @(negedge clk); #1;
        chk("run1.pc", fetch_pc, 32'h3);
        chk("run1.flush", 32'(ifid_flush), 32'h0);
        @(negedge clk); #1;
        chk("run2.pc", fetch_pc, 32'h6);

        // Redirect to 0x1000: one redirect cycle plus two flush cycles.
        @(negedge clk);
        fetch_ack = 1'b0; redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        #1;
        chk("run3.pc", fetch_pc, 32'h9);
        chk_ctl("redir", 2'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_ctl("fl0", 2'd2, 1'b0, 1'b0, 1'b1);
        chk("fl0.pc", fetch_pc, 32'h0000_1000);
        @(negedge clk); #1;
        chk_ctl("fl1", 2'd2, 1'b0, 1'b0, 1'b1);

        // Decode stall for 4 cycles with fetch_ack held high.
        @(negedge clk);
        dec_stall = 1'b1; fetch_ack = 1'b1; fetch_len = 3'd3;
        #1;
        chk_ctl("stl0", 2'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            chk("stl.pc", fetch_pc, 32'h0000_1000);
            chk("stl.stall", 32'(ifid_stall), 32'h1);
        end

        // No ack: bubble.
        @(negedge clk);
        dec_stall = 1'b0; fetch_ack = 1'b0;
        #1;
        chk("stl.cnt", 32'(stall_cnt), 32'd4);
        chk("stl.pc_end", fetch_pc, 32'h0000_1000);
        chk_ctl("bubble", 2'd1, 1'b1, 1'b0, 1'b1);

        // Zero length: accepted but no advance, no error.
        @(negedge clk);
        fetch_ack = 1'b1; fetch_len = 3'd0;
        #1;
        chk("len0.pc_pre", fetch_pc, 32'h0000_1000);
        chk("len0.flush", 32'(ifid_flush), 32'h0);

        // Redirect, halt and stall together: redirect wins.
        @(negedge clk);
        redirect_valid = 1'b1; halt_req = 1'b1; dec_stall = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        chk("len0.pc", fetch_pc, 32'h0000_1000);
        chk("len0.err", 32'(len_err), 32'h0);
        chk_ctl("multi", 2'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b0; halt_req = 1'b0; dec_stall = 1'b0;
        fetch_ack = 1'b0;
        #1;
        chk_ctl("multi.fl", 2'd2, 1'b0, 1'b0, 1'b1);
        chk("multi.pc", fetch_pc, 32'hFFFF_FFFE);
        chk("multi.cnt", 32'(stall_cnt), 32'd4);
        @(negedge clk);

        // Wrap with illegal length 7.
        @(negedge clk);
        fetch_ack = 1'b1; fetch_len = 3'd7;
        #1;
        chk("wrap.state", 32'(state_out), 32'd1);
        chk("wrap.pc_pre", fetch_pc, 32'hFFFF_FFFE);
        @(negedge clk);
        fetch_len = 3'd2;
        #1;
        chk("wrap.pc", fetch_pc, 32'h0000_0005);
        chk("wrap.err", 32'(len_err), 32'h1);

        // Halt request.
        @(negedge clk);
        fetch_ack = 1'b0; halt_req = 1'b1;
        #1;
        chk("legal.pc", fetch_pc, 32'h0000_0007);
        chk("legal.err", 32'(len_err), 32'h1);
        chk("halt.flush", 32'(ifid_flush), 32'h1);
        @(negedge clk);
        halt_req = 1'b0; dec_stall = 1'b1; fetch_ack = 1'b1;
        #1;
        chk_ctl("halt0", 2'd3, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        dec_stall = 1'b0; fetch_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        chk_ctl("halt1", 2'd3, 1'b0, 1'b0, 1'b1);
        chk("halt1.pc", fetch_pc, 32'h0000_0007);
        chk("halt1.cnt", 32'(stall_cnt), 32'd4);

        // Leave HALT via redirect, then reset mid-FLUSH between edges.
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_ctl("hfl", 2'd2, 1'b0, 1'b0, 1'b1);
        chk("hfl.pc", fetch_pc, 32'h0000_2000);
        #1 rst = 1'b1;
        #1;
        chk_ctl("arst", 2'd0, 1'b0, 1'b0, 1'b1);
        chk("arst.pc", fetch_pc, 32'h0);
        chk("arst.err", 32'(len_err), 32'h0);
        chk("arst.cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk_ctl("post", 2'd1, 1'b1, 1'b0, 1'b1);
        chk("post.pc", fetch_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch PC loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of flush cycles after a redirect; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_ack  input  1  fetch stage delivers a valid instruction this cycle.
REQ-006 fetch_len  input  3  byte length of the delivered instruction; legal 1..5.
REQ-007 dec_stall  input  1  decode cannot accept a new instruction.
REQ-008 redirect_valid  input  1  branch/exception redirect request.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 halt_req  input  1  request to stop fetching.
REQ-011 fetch_req  output  1  fetch stage enabled this cycle.
REQ-012 fetch_pc  output  32  current fetch address (registered).
REQ-013 ifid_stall  output  1  hold IF/ID pipeline register contents.
REQ-014 ifid_flush  output  1  invalidate IF/ID pipeline register.
REQ-015 state_out  output  2  current FSM state.
REQ-016 len_err  output  1  sticky flag: illegal fetch_len accepted.
REQ-017 stall_cnt  output  16  saturating count of cycles with ifid_stall=1.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FLUSH, HALT.
REQ-019 IDLE: fetch_req=0, ifid_flush=1, ifid_stall=0; next state RUN unconditionally.
REQ-020 RUN: fetch_req=1; per-cycle priority redirect_valid > halt_req > dec_stall > fetch_ack.
REQ-021 RUN + redirect_valid: fetch_pc<=redirect_pc, flush counter<=FLUSH_CYCLES-1, ifid_flush=1 this cycle, next FLUSH.
REQ-022 RUN + halt_req (no redirect): ifid_flush=1, fetch_pc unchanged, next HALT.
REQ-023 RUN + dec_stall (no redirect/halt): ifid_stall=1, ifid_flush=0, fetch_pc unchanged, regardless of fetch_ack.
REQ-024 RUN + fetch_ack, no higher-priority event: ifid_stall=0, ifid_flush=0, fetch_pc<=fetch_pc+fetch_len modulo 2^32.
REQ-025 RUN + no fetch_ack, no other event: ifid_flush=1 (bubble), fetch_pc unchanged.
REQ-026 FLUSH: fetch_req=0, ifid_flush=1, ifid_stall=0; counter decrements each cycle; counter==0 -> RUN next cycle.
REQ-027 FLUSH + redirect_valid: fetch_pc<=redirect_pc, counter reloaded to FLUSH_CYCLES-1 (latest redirect wins); halt_req, dec_stall ignored in FLUSH.
REQ-028 HALT: fetch_req=0, ifid_flush=1, ifid_stall=0; exits only on redirect_valid, per REQ-021, to FLUSH.
REQ-029 ifid_stall and ifid_flush SHALL never be 1 in the same cycle.
REQ-030 fetch_len of 0 in RUN+fetch_ack: no PC advance; values 6 or 7: PC advances by the raw value and len_err sets and stays 1 until reset.
REQ-031 stall_cnt increments every cycle ifid_stall=1, saturating at 16'hFFFF.
REQ-032 fetch_pc wraps from 32'hFFFF_FFFF+len modulo 2^32 without error.

Reset
REQ-033 rst asserted SHALL immediately force state=IDLE, fetch_pc=RESET_PC, counter=0, len_err=0, stall_cnt=0, independent of clk.
REQ-034 During reset outputs SHALL be fetch_req=0, ifid_stall=0, ifid_flush=1, state_out=IDLE.
REQ-035 Reset mid-FLUSH or mid-HALT SHALL discard pending redirect and count; first post-reset cycle is IDLE.

Structure
REQ-036 Shared package SHALL hold state encodings (IDLE=0, RUN=1, FLUSH=2, HALT=3), PC width 32, length width 3, counter width 16.
REQ-037 PC increment SHALL be a separate sub-module fetch_pc_adder (32-bit + 3-bit, no carry-out).

Verification
REQ-038 Reset release, fetch_ack=1, fetch_len=3 for 3 RUN cycles -> fetch_pc 0,3,6,9; flush=1 only in IDLE cycle.
REQ-039 RUN, redirect_valid=1 with redirect_pc=32'h0000_1000 -> fetch_pc=32'h1000 next edge, ifid_flush=1 for 3 cycles (redirect + 2 FLUSH), then RUN.
REQ-040 dec_stall=1 for 4 cycles with fetch_ack=1 -> fetch_pc constant, ifid_stall=1 each cycle, stall_cnt=4.
REQ-041 Simultaneous redirect_valid, halt_req, dec_stall in RUN -> FLUSH entered, fetch_pc=redirect_pc, ifid_stall=0.
REQ-042 fetch_pc=32'hFFFF_FFFE, fetch_ack with fetch_len=7 -> fetch_pc=32'h0000_0005, len_err=1 and stays 1.
REQ-043 rst pulse during FLUSH between edges -> outputs take reset values before next edge; IDLE then RUN.
